// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths and entry type for the register-file writeback buffer.
package rf_wb_pkg;
  localparam int REG_W = 2;
  localparam int DATA_W = 16;
  localparam int NUM_REGS = 4;
  typedef struct packed {
    logic [REG_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } rf_wb_entry_t;
endpackage

// File: rtl/rf_wb_match.sv
// rf_wb_match: newest-first lookup of a register index among the held buffer entries.
module rf_wb_match
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  rf_wb_entry_t       mem [DEPTH],
  input  logic [PTR_W-1:0]   head,
  input  logic [CNT_W-1:0]   count,
  input  logic [REG_W-1:0]   byp_reg,
  output logic               hit,
  output logic [DATA_W-1:0]  data
);
  logic [PTR_W-1:0] idx;
  // Walk oldest to newest so the last match written is the newest one.
  always_comb begin
    hit = 1'b0;
    data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < count && mem[idx].idx == byp_reg) begin
        hit = 1'b1;
        data = mem[idx].data;
      end
    end
  end
endmodule

// File: rtl/rf_writeback_buffer.sv
// rf_writeback_buffer: FIFO that drains writeback results into the register file write port.
// Optional read-side bypass lookup of pending writes when RF_WB_BYPASS_EN is defined.
module rf_writeback_buffer
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_en,
  output logic              rf_reg_write,
  output logic [REG_W-1:0]  rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [REG_W-1:0]  byp_reg1,
  input  logic [REG_W-1:0]  byp_reg2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  rf_wb_entry_t mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic push, pop;
  assign empty = count == '0;
  assign in_ready = count != CNT_W'(DEPTH);
  assign push = in_valid && in_ready;
  assign pop = rf_reg_write;
  assign rf_reg_write = drain_en && !empty;
  assign rf_write_reg = empty ? '0 : mem[head].idx;
  assign rf_write_data = empty ? '0 : mem[head].data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  // Storage needs no reset: count gates every use of an entry.
  always_ff @(posedge clk)
    if (push) mem[tail] <= '{idx: in_reg, data: in_data};
`ifdef RF_WB_BYPASS_EN
  rf_wb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_match1 (
    .mem(mem), .head(head), .count(count), .byp_reg(byp_reg1), .hit(byp_hit1), .data(byp_data1)
  );
  rf_wb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_match2 (
    .mem(mem), .head(head), .count(count), .byp_reg(byp_reg2), .hit(byp_hit2), .data(byp_data2)
  );
`endif
endmodule

// File: tb/tb_rf_writeback_buffer.sv
// tb_rf_writeback_buffer: directed scoreboard bench for rf_writeback_buffer.
// Exercises the bypass lookup too when RF_WB_BYPASS_EN is defined.
module tb_rf_writeback_buffer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] in_reg = '0;
  logic [15:0] in_data = '0;
  logic drain_en = 1'b0;
  logic rf_reg_write;
  logic [1:0] rf_write_reg;
  logic [15:0] rf_write_data;
  logic [2:0] count;
  logic empty;
`ifdef RF_WB_BYPASS_EN
  logic [1:0] byp_reg1 = '0, byp_reg2 = '0;
  logic byp_hit1, byp_hit2;
  logic [15:0] byp_data1, byp_data2;
`endif
  int checks = 0;
  int failures = 0;
  int writes = 0;
  logic [17:0] sb [$];
  logic [15:0] rfm [4];
  always #5 clk = ~clk;
  rf_writeback_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en), .rf_reg_write(rf_reg_write),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data), .count(count), .empty(empty)
`ifdef RF_WB_BYPASS_EN
    , .byp_reg1(byp_reg1), .byp_reg2(byp_reg2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // Sample at negedge: pop/compare any RF write, record any accepted push, then take the edge.
  task automatic tick();
    logic acc;
    @(negedge clk);
    if (rf_reg_write) begin
      writes++;
      if (sb.size() == 0) chk("unexpected_write", {14'd0, rf_write_reg, rf_write_data}, 32'hdead);
      else begin
        chk("wb_order", {14'd0, rf_write_reg, rf_write_data}, {14'd0, sb[0]});
        void'(sb.pop_front());
      end
      rfm[rf_write_reg] = rf_write_data;
    end
    acc = in_valid && in_ready;
    if (acc) sb.push_back({in_reg, in_data});
    @(posedge clk);
    #1;
    if (acc) in_valid = 1'b0;
  endtask
  task automatic push(input logic [1:0] r, input logic [15:0] d);
    in_valid = 1'b1;
    in_reg = r;
    in_data = d;
    tick();
  endtask
  task automatic drain_all();
    drain_en = 1'b1;
    for (int i = 0; i < 12 && !(empty && !in_valid); i++) tick();
    chk("drain_bound_empty", {31'd0, empty}, 32'd1);
  endtask
  initial begin
    int w0;
    for (int i = 0; i < 4; i++) rfm[i] = '0;
    drain_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rf_reg_write", rf_reg_write, 0);
    chk("rst_write_reg", rf_write_reg, 0);
    chk("rst_write_data", rf_write_data, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // Test 1: single write, one-cycle latency
    push(2'd2, 16'h1234);
    chk("t1_reg_write", rf_reg_write, 1);
    chk("t1_write_reg", rf_write_reg, 2);
    chk("t1_write_data", rf_write_data, 16'h1234);
    chk("t1_count1", count, 1);
    tick();
    chk("t1_count0", count, 0);
    chk("t1_empty", empty, 1);
    chk("t1_rf_r2", rfm[2], 16'h1234);
    // Test 2: fill with drain off, fifth held off until space
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push(2'(i), 16'h0100 + 16'(i));
    chk("t2_in_ready", in_ready, 0);
    chk("t2_count_full", count, 4);
    chk("t2_no_write", rf_reg_write, 0);
    in_valid = 1'b1;
    in_reg = 2'd1;
    in_data = 16'h0055;
    tick();
    chk("t2_held_off", count, 4);
    chk("t2_still_valid", in_valid, 1);
    w0 = writes;
    drain_en = 1'b1;
    tick();
    chk("t2_count_after_pop", count, 3);
    drain_all();
    chk("t2_writes", writes - w0, 5);
    chk("t2_rf_r0", rfm[0], 16'h0100);
    chk("t2_rf_r3", rfm[3], 16'h0103);
    chk("t2_rf_r1", rfm[1], 16'h0055);
    // Test 3: same register twice, in order
    w0 = writes;
    push(2'd1, 16'd5);
    push(2'd1, 16'd9);
    drain_all();
    chk("t3_writes", writes - w0, 2);
    chk("t3_rf_r1", rfm[1], 16'd9);
    // Test 4: continuous push+drain, count steady at 1
    push(2'd3, 16'h0001);
    for (int i = 2; i <= 10; i++) begin
      push(2'(i), 16'(i));
      chk("t4_count_steady", count, 1);
    end
    drain_all();
    chk("t4_rf_r2", rfm[2], 16'h000a);
    // Test 5: async reset discards held entries
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) push(2'(i), 16'hbee0 + 16'(i));
    chk("t5_count3", count, 3);
    #2;
    drain_en = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_rf_reg_write", rf_reg_write, 0);
    sb.delete();
    #3;
    reset_n = 1'b1;
    w0 = writes;
    repeat (4) tick();
    chk("t5_no_stale", writes - w0, 0);
`ifdef RF_WB_BYPASS_EN
    // Test 6: bypass newest match
    drain_en = 1'b0;
    push(2'd3, 16'd7);
    push(2'd3, 16'd8);
    push(2'd0, 16'd2);
    byp_reg1 = 2'd3;
    byp_reg2 = 2'd1;
    #1;
    chk("t6_hit1", byp_hit1, 1);
    chk("t6_data1", byp_data1, 16'd8);
    chk("t6_hit2", byp_hit2, 0);
    chk("t6_data2", byp_data2, 0);
    byp_reg2 = 2'd0;
    #1;
    chk("t6_hit2_r0", byp_hit2, 1);
    chk("t6_data2_r0", byp_data2, 16'd2);
    drain_all();
    #1;
    chk("t6_hit1_after", byp_hit1, 0);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
